// File: rtl/centroid_moment_accum.sv
// centroid_moment_accum: first-order patch moment (m01) for the ORB orientation path.
// Accepts one unsigned row sum per valid cycle over a ROWS-row patch, weights each
// row by its signed offset from the patch centre and accumulates the result.
// Optional feature macro CENTROID_M00_EN also builds the zeroth-moment (m00) accumulator;
// without it m00 is tied to zero and m01/out_valid timing is identical.
module centroid_moment_accum #(
  parameter int ROWS   = 37,
  parameter int BW_IN  = 14,
  parameter int BW_OUT = 22,
  parameter int BW_M00 = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [BW_IN-1:0]         row_sum,
  output logic                     out_valid,
  output logic signed [BW_OUT-1:0] m01,
  output logic [BW_M00-1:0]        m00,
  output logic                     sof_err
);

  // Row index and offset are 6 bits wide: 0..36 and -18..+18 respectively.
  localparam int             CW       = 6;
  localparam logic [CW-1:0]  LAST_IDX = CW'(ROWS - 1);
  localparam logic [CW-1:0]  HALF_IDX = CW'((ROWS - 1) / 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;

  logic           take_row;
  logic           row_first;
  logic           row_last;
  logic [CW-1:0]  row_idx;

  logic [CW-1:0]             off_u;
  logic signed [BW_OUT-1:0]  off_ext;
  logic signed [BW_OUT-1:0]  rs_ext;
  logic signed [BW_OUT-1:0]  prod_c;

  logic                      s1_valid;
  logic                      s1_first;
  logic                      s1_last;
  logic signed [BW_OUT-1:0]  s1_prod;

  logic signed [BW_OUT-1:0]  acc;
  logic signed [BW_OUT-1:0]  acc_next;

  // Decide whether this cycle's row belongs to a patch, and which row it is.
  // A sof row always restarts the patch at row 0, whatever state we are in.
  always_comb begin
    take_row  = 1'b0;
    row_first = 1'b0;
    row_last  = 1'b0;
    row_idx   = '0;
    if (in_valid) begin
      if (in_sof) begin
        take_row  = 1'b1;
        row_first = 1'b1;
        row_idx   = '0;
      end else if (state == ACCUM) begin
        take_row  = 1'b1;
        row_idx   = cnt;
        row_last  = (cnt == LAST_IDX);
      end
    end
  end

  // Signed row weight times the row sum, both extended to the accumulator width.
  always_comb begin
    off_u   = row_idx - HALF_IDX;
    off_ext = {{(BW_OUT - CW){off_u[CW-1]}}, off_u};
    rs_ext  = {{(BW_OUT - BW_IN){1'b0}}, row_sum};
    prod_c  = rs_ext * off_ext;
  end

  // Patch framing FSM: tracks the row counter and flags a sof that cuts a patch short.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sof_err <= 1'b0;
    end else if (ena) begin
      sof_err <= in_valid & in_sof & (state == ACCUM);
      if (take_row) begin
        if (row_last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= ACCUM;
          cnt   <= row_idx + CW'(1);
        end
      end
    end
  end

  // Stage 1: register the weighted row together with its first/last tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (ena) begin
      s1_valid <= take_row;
      s1_first <= row_first;
      s1_last  <= row_last;
      s1_prod  <= prod_c;
    end
  end

  // A first-tagged row overwrites the accumulator so no earlier patch can leak in.
  always_comb begin
    acc_next = s1_first ? s1_prod : (acc + s1_prod);
  end

  // Stage 2: accumulate m01 and publish it with a one-cycle pulse on the last row.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      m01       <= '0;
      out_valid <= 1'b0;
    end else if (ena) begin
      out_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        acc <= acc_next;
        if (s1_last) begin
          m01 <= acc_next;
        end
      end
    end
  end

`ifdef CENTROID_M00_EN
  logic [BW_IN-1:0]  s1_row;
  logic [BW_M00-1:0] acc0;
  logic [BW_M00-1:0] row_ext;
  logic [BW_M00-1:0] acc0_next;

  // Zeroth moment follows the same first/last tagging as m01.
  always_comb begin
    row_ext   = {{(BW_M00 - BW_IN){1'b0}}, s1_row};
    acc0_next = s1_first ? row_ext : (acc0 + row_ext);
  end

  // Stage 1 copy of the raw row sum for the m00 path.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_row <= '0;
    end else if (ena) begin
      s1_row <= row_sum;
    end
  end

  // Stage 2 m00 accumulator and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc0 <= '0;
      m00  <= '0;
    end else if (ena) begin
      if (s1_valid) begin
        acc0 <= acc0_next;
        if (s1_last) begin
          m00 <= acc0_next;
        end
      end
    end
  end
`else
  assign m00 = '0;
`endif

endmodule

// File: tb/tb_centroid_moment_accum.sv
// Self-checking bench for centroid_moment_accum.
// A reference model keeps each patch as a queue of row values and computes the
// moments directly as sum((i - centre) * row[i]) and sum(row[i]).
module tb_centroid_moment_accum;

  localparam int ROWS   = 37;
  localparam int BW_IN  = 14;
  localparam int BW_OUT = 22;
  localparam int BW_M00 = 19;
  localparam int MAXROW = 9435;

  logic                     clk;
  logic                     rst;
  logic                     ena;
  logic                     in_valid;
  logic                     in_sof;
  logic [BW_IN-1:0]         row_sum;
  logic                     out_valid;
  logic signed [BW_OUT-1:0] m01;
  logic [BW_M00-1:0]        m00;
  logic                     sof_err;

  int checks   = 0;
  int failures = 0;

  centroid_moment_accum #(
    .ROWS(ROWS), .BW_IN(BW_IN), .BW_OUT(BW_OUT), .BW_M00(BW_M00)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_sof(in_sof),
    .row_sum(row_sum), .out_valid(out_valid), .m01(m01), .m00(m00), .sof_err(sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, asserts, reports.
  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    int due;
    int m01;
    int m00;
  } exp_t;

  exp_t expQ[$];
  int   patchQ[$];
  bit   inPatch    = 0;
  bit   modelOn    = 0;
  int   nEdge      = 0;
  int   sofErrDue  = -1;
  int   lastM01    = 0;
  int   lastM00    = 0;
  int   pulses     = 0;
  int   pulseEdge  = -1;
  int   expectedPulses = 0;
  int   patchRows[ROWS];

  function automatic exp_t moments(input int due);
    exp_t e;
    e.due = due;
    e.m01 = 0;
    e.m00 = 0;
    for (int i = 0; i < ROWS; i++) begin
      e.m01 += (i - (ROWS - 1) / 2) * patchQ[i];
      e.m00 += patchQ[i];
    end
    return e;
  endfunction

  // Edge bookkeeping: reset clears the model, each enabled edge advances time.
  always @(posedge clk) begin
    if (rst) begin
      modelOn   = 1;
      inPatch   = 0;
      patchQ.delete();
      expQ.delete();
      sofErrDue = -1;
      lastM01   = 0;
      lastM00   = 0;
    end else if (ena && modelOn) begin
      if (expQ.size() > 0 && expQ[0].due == nEdge) void'(expQ.pop_front());
      nEdge++;
    end
  end

  // Mid-cycle: compare visible outputs, then feed the upcoming sampled inputs to the model.
  always @(negedge clk) begin
    if (modelOn) begin
      int expOv;
      int expM00;
      expOv = 0;
      if (expQ.size() > 0 && expQ[0].due == nEdge) begin
        expOv   = 1;
        lastM01 = expQ[0].m01;
        lastM00 = expQ[0].m00;
      end
`ifdef CENTROID_M00_EN
      expM00 = lastM00;
`else
      expM00 = 0;
`endif
      checkOutput("out_valid", out_valid, expOv);
      checkOutput("sof_err", sof_err, (sofErrDue == nEdge) ? 1 : 0);
      checkOutput("m01", m01, lastM01);
      checkOutput("m00", m00, expM00);
      if (out_valid === 1'b1 && pulseEdge != nEdge) begin
        pulses++;
        pulseEdge = nEdge;
      end
      if (!rst && ena && in_valid) begin
        if (in_sof) begin
          if (inPatch) sofErrDue = nEdge + 1;
          patchQ.delete();
          patchQ.push_back(int'(row_sum));
          inPatch = 1;
        end else if (inPatch) begin
          patchQ.push_back(int'(row_sum));
        end
        if (inPatch && patchQ.size() == ROWS) begin
          expQ.push_back(moments(nEdge + 2));
          inPatch = 0;
          patchQ.delete();
        end
      end
    end
  end

  // Drive one row (or idle) and let it be sampled, optionally after an ena stall.
  task automatic applyStimulus(input logic v, input logic s, input int r, input int stall);
    in_valid = v;
    in_sof   = s;
    row_sum  = BW_IN'(r);
    repeat (stall) begin
      ena = 1'b0;
      @(posedge clk);
      #1;
    end
    ena = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic feedPatch(input int stallA, input int stallB, input bit jitter);
    for (int i = 0; i < ROWS; i++) begin
      int st;
      st = (i == stallA || i == stallB) ? 5 : 0;
      if (jitter && $urandom_range(0, 3) == 0)
        applyStimulus(1'b0, 1'b0, int'($urandom_range(0, MAXROW)), 0);
      if (jitter && st == 0 && $urandom_range(0, 7) == 0)
        st = int'($urandom_range(1, 3));
      applyStimulus(1'b1, (i == 0), patchRows[i], st);
    end
    expectedPulses++;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_sof = 1'b0; row_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_m01", m01, 0);
    checkOutput("reset_m00", m00, 0);
    checkOutput("reset_sof_err", sof_err, 0);

    // Rows without sof while idle are dropped.
    applyStimulus(1'b1, 1'b0, 500, 0);
    applyStimulus(1'b1, 1'b0, 700, 0);

    // Uniform patch.
    foreach (patchRows[i]) patchRows[i] = 100;
    feedPatch(-1, -1, 0);
    idle(3);

    // Single extreme rows, then all-max.
    foreach (patchRows[i]) patchRows[i] = (i == ROWS - 1) ? MAXROW : 0;
    feedPatch(-1, -1, 0);
    idle(3);
    foreach (patchRows[i]) patchRows[i] = (i == 0) ? MAXROW : 0;
    feedPatch(-1, -1, 0);
    idle(3);
    foreach (patchRows[i]) patchRows[i] = MAXROW;
    feedPatch(-1, -1, 0);

    // Back-to-back: no bubble between patches.
    foreach (patchRows[i]) patchRows[i] = i;
    feedPatch(-1, -1, 0);
    foreach (patchRows[i]) patchRows[i] = 1;
    feedPatch(-1, -1, 0);
    idle(3);

    // Stalls at rows 10 and 36.
    feedPatch(10, 36, 0);
    idle(3);

    // sof at row 20 of a partial patch, then a full patch from that sof.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, (i == 0), 3000 + i, 0);
    foreach (patchRows[i]) patchRows[i] = int'($urandom_range(0, MAXROW));
    feedPatch(-1, -1, 0);
    idle(3);

    // Reset in the middle of a patch.
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, (i == 0), 200 + 7 * i, 0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1234, 0);
    rst = 1'b0;
    checkOutput("midrst_m01", m01, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 900 + i, 0);
    foreach (patchRows[i]) patchRows[i] = int'($urandom_range(0, MAXROW));
    feedPatch(-1, -1, 0);
    idle(3);

    // Random patches with gaps and short stalls.
    for (int p = 0; p < 6; p++) begin
      foreach (patchRows[i]) patchRows[i] = int'($urandom_range(0, MAXROW));
      feedPatch(-1, -1, 1);
    end
    idle(4);
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ena = 1'b1;
    idle(2);

    checkOutput("pulse_count", pulses, expectedPulses);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
